// File: rtl/tx_frame_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// tx_frame_scheduler_pkg
// Shared definitions for the TX frame scheduler and the serial transmitter:
//   - packet geometry (8-bit header + 128-bit payload = 136-bit packet)
//   - scheduler state encoding
//   - a small modulo-increment helper used by the round-robin logic
// No ports (package).
// ---------------------------------------------------------------------------
package tx_frame_scheduler_pkg;

   localparam int HDR_W     = 8;
   localparam int PAYLOAD_W = 128;
   localparam int PKT_W     = HDR_W + PAYLOAD_W;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_GAP       = 3'd4
   } sched_state_t;

   // (a + b) modulo n, for operands already in range 0..n-1
   function automatic int wrap_add(input int a, input int b, input int n);
      int s;
      s = a + b;
      while (s >= n) s = s - n;
      return s;
   endfunction

endpackage

// File: rtl/tx_frame_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tx_frame_scheduler_rr_arbiter
// Purely combinational round-robin picker: returns the first asserted request
// at or after ptr, searching upward and wrapping modulo NUM_REQ.
// Ports:
//   req    in   NUM_REQ   request vector
//   ptr    in   GRANT_W   highest-priority index for this pick
//   grant  out  NUM_REQ   one-hot grant (all zero when no request)
//   index  out  GRANT_W   encoded index of the granted request
//   found  out  1         at least one request was asserted
// ---------------------------------------------------------------------------
module tx_frame_scheduler_rr_arbiter
   import tx_frame_scheduler_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int GRANT_W = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [GRANT_W-1:0] ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [GRANT_W-1:0] index,
   output logic               found
);

   // Walk the requests starting at ptr; the first hit wins and later hits
   // are ignored, which keeps the grant one-hot.
   always_comb begin
      int j;
      logic [GRANT_W-1:0] jj;
      grant = '0;
      index = '0;
      found = 1'b0;
      j     = 0;
      jj    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j  = wrap_add(int'(ptr), k, NUM_REQ);
         jj = GRANT_W'(j);
         if (!found && req[jj]) begin
            found     = 1'b1;
            grant[jj] = 1'b1;
            index     = jj;
         end
      end
   end

endmodule

// File: rtl/tx_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tx_frame_scheduler
// Shares one serial transmitter between NUM_REQ packet sources. A source is
// picked round-robin while idle, its 136-bit packet and test flag are
// captured, and the transmitter is sequenced: start pulse, wait for busy to
// rise (with timeout), wait for busy to fall, then an inter-frame gap.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_valid      in   NUM_REQ          source i has a packet pending
//   req_packet     in   NUM_REQ*136      source i packet at [i*136 +: 136]
//   req_test       in   NUM_REQ          per-source error-injection flag
//   req_ready      out  NUM_REQ          one-hot accept pulse (capture cycle)
//   req_done       out  NUM_REQ          one-hot frame-finished pulse
//   tx_start       out  1                start pulse to the transmitter
//   tx_packet      out  136              captured packet
//   tx_test_mode   out  1                captured test flag of the owner
//   tx_busy        in   1                transmitter busy
//   grant_id       out  GRANT_W          index of current/last owner
//   err_timeout    out  1                busy did not rise within BUSY_TMO
//   frame_cnt      out  16               completed frames (wrapping)
// ---------------------------------------------------------------------------
module tx_frame_scheduler
   import tx_frame_scheduler_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int GRANT_W    = 2,
   parameter int IFG_CYCLES = 12,
   parameter int BUSY_TMO   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*PKT_W-1:0] req_packet,
   input  logic [NUM_REQ-1:0]       req_test,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [NUM_REQ-1:0]       req_done,
   output logic                     tx_start,
   output logic [PKT_W-1:0]         tx_packet,
   output logic                     tx_test_mode,
   input  logic                     tx_busy,
   output logic [GRANT_W-1:0]       grant_id,
   output logic                     err_timeout,
   output logic [15:0]              frame_cnt
);

   // A timeout or a finished frame skips the gap state entirely when no gap
   // is configured, so the next grant can happen one cycle later.
   localparam sched_state_t AFTER_FRAME = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;

   sched_state_t        state;
   sched_state_t        state_next;
   logic [15:0]         cnt;
   logic                cnt_clr;
   logic                cnt_inc;
   logic                accept;
   logic [GRANT_W-1:0]  ptr;
   logic [NUM_REQ-1:0]  arb_grant;
   logic [GRANT_W-1:0]  arb_index;
   logic                arb_found;
   logic [PKT_W-1:0]    sel_packet;
   logic                sel_test;

   tx_frame_scheduler_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .GRANT_W (GRANT_W)
   ) u_arbiter (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (arb_grant),
      .index (arb_index),
      .found (arb_found)
   );

   // Packet/test-flag mux for the source the arbiter is pointing at.
   always_comb begin
      sel_packet = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_index == GRANT_W'(i)) begin
            sel_packet = req_packet[i*PKT_W +: PKT_W];
         end
      end
      sel_test = req_test[arb_index];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and pulse outputs. The shared counter times both the busy
   // timeout and the inter-frame gap; it is cleared on entry to each phase.
   // Pulses are suppressed while reset is asserted so an abandoned frame
   // never reports completion.
   always_comb begin
      state_next  = state;
      tx_start    = 1'b0;
      req_done    = '0;
      err_timeout = 1'b0;
      accept      = 1'b0;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!tx_busy && arb_found) begin
               accept     = 1'b1;
               state_next = ST_START;
            end
         end
         ST_START: begin
            tx_start   = 1'b1;
            cnt_clr    = 1'b1;
            state_next = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (tx_busy) begin
               state_next = ST_WAIT_DONE;
            end else if (cnt == 16'(BUSY_TMO)) begin
               err_timeout = 1'b1;
               cnt_clr     = 1'b1;
               state_next  = AFTER_FRAME;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               req_done[grant_id] = 1'b1;
               cnt_clr            = 1'b1;
               state_next         = AFTER_FRAME;
            end
         end
         ST_GAP: begin
            if (cnt == 16'(IFG_CYCLES - 1)) begin
               state_next = ST_IDLE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
      if (rst) begin
         tx_start    = 1'b0;
         req_done    = '0;
         err_timeout = 1'b0;
         accept      = 1'b0;
      end
   end

   assign req_ready = accept ? arb_grant : '0;

   // Datapath: phase counter, round-robin pointer, capture register and the
   // completed-frame counter. Capture happens only on an accept cycle so the
   // transmitter sees a stable packet for the whole frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt          <= '0;
         ptr          <= '0;
         grant_id     <= '0;
         tx_packet    <= '0;
         tx_test_mode <= 1'b0;
         frame_cnt    <= '0;
      end else begin
         if (cnt_clr) begin
            cnt <= '0;
         end else if (cnt_inc) begin
            cnt <= cnt + 16'd1;
         end
         if (accept) begin
            grant_id     <= arb_index;
            tx_packet    <= sel_packet;
            tx_test_mode <= sel_test;
            ptr          <= GRANT_W'(wrap_add(int'(arb_index), 1, NUM_REQ));
         end
         if (|req_done) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tx_frame_scheduler
// Self-checking bench: a timestamp-based model of the scheduler's rules is
// compared against the DUT every cycle, directed scenarios pin literal
// expectations, then randomized traffic (valids, packets, test flags,
// transmitter delays, stray resets) runs against the same model.
// ---------------------------------------------------------------------------
module tb_tx_frame_scheduler;

   localparam int NUM_REQ    = 4;
   localparam int GRANT_W    = 2;
   localparam int IFG_CYCLES = 12;
   localparam int BUSY_TMO   = 4;
   localparam int PW         = 136;
   localparam int NEVER      = 32'h3fff_ffff;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*PW-1:0] req_packet;
   logic [NUM_REQ-1:0]    req_test;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ-1:0]    req_done;
   logic                  tx_start;
   logic [PW-1:0]         tx_packet;
   logic                  tx_test_mode;
   logic                  tx_busy;
   logic [GRANT_W-1:0]    grant_id;
   logic                  err_timeout;
   logic [15:0]           frame_cnt;

   tx_frame_scheduler #(
      .NUM_REQ    (NUM_REQ),
      .GRANT_W    (GRANT_W),
      .IFG_CYCLES (IFG_CYCLES),
      .BUSY_TMO   (BUSY_TMO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_packet   (req_packet),
      .req_test     (req_test),
      .req_ready    (req_ready),
      .req_done     (req_done),
      .tx_start     (tx_start),
      .tx_packet    (tx_packet),
      .tx_test_mode (tx_test_mode),
      .tx_busy      (tx_busy),
      .grant_id     (grant_id),
      .err_timeout  (err_timeout),
      .frame_cnt    (frame_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   // Transmitter behaviour: busy rises d cycles after tx_start, lasts len.
   int busy_rise = 0;
   int busy_fall = 0;
   int fix_d     = 0;
   int fix_len   = 0;
   bit fix_never = 1'b0;

   // Reference model state (timestamps rather than states).
   bit           model_on = 1'b0;
   int           m_ptr, m_grant, m_acc, m_seen_cyc, m_eligible;
   bit           m_active, m_seen, m_test;
   logic [PW-1:0] m_pkt;
   logic [15:0]  m_frame_cnt;

   logic [NUM_REQ-1:0] e_ready, e_done;
   logic               e_start, e_tmo;
   int                 pick, j;

   task automatic checkOutput(input string name, input logic [PW-1:0] actual,
                              input logic [PW-1:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
      end
   endtask

   function automatic logic [PW-1:0] rand_pkt();
      logic [159:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return t[PW-1:0];
   endfunction

   function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic model_reset();
      m_ptr       = 0;
      m_grant     = 0;
      m_acc       = 0;
      m_seen_cyc  = 0;
      m_eligible  = 0;
      m_active    = 1'b0;
      m_seen      = 1'b0;
      m_test      = 1'b0;
      m_pkt       = '0;
      m_frame_cnt = '0;
   endtask

   // Advance one cycle; inputs for the new cycle are set 2 time units after
   // the edge. The transmitter reacts to a tx_start it sees in this cycle.
   task automatic tick();
      int d;
      int len;
      @(posedge clk);
      #2;
      if (tx_start === 1'b1) begin
         if (fix_never) begin
            d = NEVER;
         end else if (fix_d != 0) begin
            d = fix_d;
         end else begin
            case ($urandom_range(0, 9))
               7:       d = BUSY_TMO + 2;
               8, 9:    d = NEVER;
               default: d = $urandom_range(1, BUSY_TMO + 1);
            endcase
         end
         len = (fix_len != 0) ? fix_len : $urandom_range(1, 15);
         if (d == NEVER) begin
            busy_rise = NEVER;
            busy_fall = NEVER;
         end else begin
            busy_rise = cyc + d;
            busy_fall = cyc + d + len;
         end
      end
      tx_busy = (cyc >= busy_rise) && (cyc < busy_fall);
   endtask

   // what: 0 = req_ready, 1 = req_done, 2 = err_timeout
   task automatic wait_for(input int what, input int limit, output bit got);
      got = 1'b0;
      for (int i = 0; i < limit; i++) begin
         #1;
         if ((what == 0 && req_ready != 0) || (what == 1 && req_done != 0) ||
             (what == 2 && err_timeout)) begin
            got = 1'b1;
            return;
         end
         tick();
      end
   endtask

   task automatic applyStimulus();
      for (int i = 0; i < NUM_REQ; i++) begin
         if ($urandom_range(0, 7) == 0) req_valid[i] = ~req_valid[i];
         if ($urandom_range(0, 15) == 0) req_test[i] = ~req_test[i];
         req_packet[i*PW +: PW] = rand_pkt();
      end
      rst = ($urandom_range(0, 199) == 0);
   endtask

   // Per-cycle comparison against the model. Pulse outputs are derived from
   // timestamps: accept cycle, the cycle busy was first seen, and the first
   // cycle a new grant is allowed.
   always @(negedge clk) begin
      if (model_on) begin
         e_ready = '0;
         e_done  = '0;
         e_start = 1'b0;
         e_tmo   = 1'b0;
         pick    = -1;
         if (!rst) begin
            if (!m_active && cyc >= m_eligible && !tx_busy) begin
               for (int k = 0; k < NUM_REQ; k++) begin
                  j = (m_ptr + k) % NUM_REQ;
                  if (pick < 0 && req_valid[j]) pick = j;
               end
            end
            if (pick >= 0) e_ready[pick] = 1'b1;
            if (m_active) begin
               e_start = (cyc == m_acc + 1);
               if (!m_seen) begin
                  e_tmo = !tx_busy && (cyc == m_acc + 2 + BUSY_TMO);
               end else if (cyc > m_seen_cyc && !tx_busy) begin
                  e_done[m_grant] = 1'b1;
               end
            end
         end
         checkOutput("req_ready", PW'(req_ready), PW'(e_ready));
         checkOutput("tx_start", PW'(tx_start), PW'(e_start));
         checkOutput("req_done", PW'(req_done), PW'(e_done));
         checkOutput("err_timeout", PW'(err_timeout), PW'(e_tmo));
         checkOutput("grant_id", PW'(grant_id), PW'(m_grant));
         checkOutput("tx_packet", tx_packet, m_pkt);
         checkOutput("tx_test_mode", PW'(tx_test_mode), PW'(m_test));
         checkOutput("frame_cnt", PW'(frame_cnt), PW'(m_frame_cnt));
         if (rst) begin
            model_reset();
         end else if (pick >= 0) begin
            m_active = 1'b1;
            m_seen   = 1'b0;
            m_acc    = cyc;
            m_grant  = pick;
            m_pkt    = req_packet[pick*PW +: PW];
            m_test   = req_test[pick];
            m_ptr    = (pick + 1) % NUM_REQ;
         end else if (m_active) begin
            if (!m_seen && cyc >= m_acc + 2 && tx_busy) begin
               m_seen     = 1'b1;
               m_seen_cyc = cyc;
            end
            if (e_tmo || e_done != 0) begin
               m_active   = 1'b0;
               m_eligible = cyc + IFG_CYCLES + 1;
               if (e_done != 0) m_frame_cnt = m_frame_cnt + 16'd1;
            end
         end
      end
   end

   initial begin
      bit            got;
      int            s, t, n, last_done, gap, cnt, done_seen;
      int            seq [8];
      int            exp_seq [8];
      logic [PW-1:0] pkt;

      rst        = 1'b1;
      req_valid  = '0;
      req_packet = '0;
      req_test   = '0;
      tx_busy    = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      model_reset();
      model_on = 1'b1;

      // Single source, transmitter busy one cycle after start for 40 cycles.
      $display("[TB] single-source frame");
      fix_d   = 1;
      fix_len = 40;
      pkt     = {8'h13, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210};
      req_packet[0 +: PW] = pkt;
      req_valid = 4'b0001;
      wait_for(0, 20, got);
      checkOutput("t1_ready", PW'(req_ready), PW'(4'b0001));
      tick();
      req_valid = '0;
      #1;
      s = cyc;
      checkOutput("t1_start", PW'(tx_start), PW'(1));
      checkOutput("t1_packet", tx_packet, pkt);
      wait_for(1, 100, got);
      checkOutput("t1_done", PW'(req_done), PW'(4'b0001));
      // busy 1 cycle after start, for 40 cycles: done 41 cycles after start
      checkOutput("t1_done_latency", PW'(cyc - s), PW'(41));
      tick();
      #1;
      checkOutput("t1_frame_cnt", PW'(frame_cnt), PW'(1));

      // Reset while the transmitter is mid-frame.
      $display("[TB] reset during frame");
      req_valid = 4'b0001;
      wait_for(0, 50, got);
      checkOutput("t5_ready_seen", PW'(got), PW'(1));
      repeat (6) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checkOutput("t5_frame_cnt", PW'(frame_cnt), PW'(0));
      checkOutput("t5_packet", tx_packet, '0);
      checkOutput("t5_busy_stale", PW'(tx_busy), PW'(1));
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (req_ready != 0 || req_done != 0) cnt++;
         tick();
         #1;
      end
      checkOutput("t5_no_grant_while_busy", PW'(cnt), PW'(0));
      req_valid = '0;
      for (int i = 0; i < 100 && tx_busy; i++) tick();

      // All sources valid: round-robin order, gap, then wrap with two sources.
      $display("[TB] round-robin order and gap");
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      fix_d     = 1;
      fix_len   = 3;
      req_valid = 4'b1111;
      n         = 0;
      last_done = -1000;
      gap       = -1;
      for (int i = 0; i < 600 && n < 8; i++) begin
         #1;
         if (req_done != 0) last_done = cyc;
         if (req_ready != 0) begin
            if (n == 1) gap = cyc - last_done;
            seq[n] = onehot_idx(req_ready);
            n++;
         end
         tick();
         if (n >= 6) req_valid = 4'b0011;
      end
      req_valid = '0;
      exp_seq = '{0, 1, 2, 3, 0, 1, 0, 1};
      for (int k = 0; k < 8; k++) checkOutput($sformatf("t2_grant%0d", k), PW'(seq[k]), PW'(exp_seq[k]));
      checkOutput("t2_gap", PW'(gap), PW'(IFG_CYCLES + 1));

      // Test flag travels with source 2, then clears for source 1.
      $display("[TB] test-mode flag");
      req_valid = 4'b0110;
      req_test  = 4'b0100;
      wait_for(0, 100, got);
      checkOutput("t6_ready", PW'(req_ready), PW'(4'b0100));
      tick();
      #1;
      checkOutput("t6_mode_start", PW'(tx_test_mode), PW'(1));
      wait_for(1, 100, got);
      checkOutput("t6_mode_done", PW'(tx_test_mode), PW'(1));
      wait_for(0, 100, got);
      checkOutput("t6_ready2", PW'(req_ready), PW'(4'b0010));
      tick();
      req_valid = '0;
      req_test  = '0;
      #1;
      checkOutput("t6_mode_cleared", PW'(tx_test_mode), PW'(0));

      // Transmitter never goes busy.
      $display("[TB] busy timeout");
      fix_never = 1'b1;
      req_valid = 4'b0001;
      wait_for(0, 100, got);
      tick();
      req_valid = '0;
      s         = cyc;
      t         = -1;
      done_seen = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         #1;
         if (err_timeout && t < 0) t = cyc;
         if (req_done != 0) done_seen = 1;
      end
      // WAIT_BUSY is entered one cycle after start, timeout BUSY_TMO later
      checkOutput("t4_timeout_latency", PW'(t - s), PW'(5));
      checkOutput("t4_no_done", PW'(done_seen), PW'(0));
      fix_never = 1'b0;
      fix_d     = 0;
      fix_len   = 0;

      // Randomized traffic against the model.
      $display("[TB] random traffic");
      for (int i = 0; i < 4000; i++) begin
         tick();
         applyStimulus();
      end
      tick();
      rst       = 1'b0;
      req_valid = '0;
      repeat (5) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
